// File: rtl/gf2m_digit_mul_163b.sv
// -----------------------------------------------------------------------------
// gf2m_digit_mul_163b
//
// Digit-serial multiplier in GF(2^163) over the B-163 field polynomial
//   f(x) = x^163 + x^7 + x^6 + x^3 + 1
// Operands use a polynomial basis: bit i holds the coefficient of x^i.
// The registered product feeds the point-arithmetic adder downstream.
//
// Operand B is consumed MSB-first, DIGIT bits per cycle, Horner style:
//   acc <= (acc * x^DIGIT mod f) ^ (A * b_digit mod f)
// B is zero-padded on its MSB side to NCYC*DIGIT bits, so the first
// digit(s) may be partly or entirely zero.
//
// Handshake (start / busy / done):
//   - start is sampled only while the FSM is IDLE; when it is high at a
//     rising edge the operands are latched and the operation begins.
//     start seen in RUN or DONE is dropped (no queuing).
//   - busy is high from the edge that accepts start until the edge that
//     writes mul_out (NCYC+1 cycles).
//   - done is a one-cycle pulse in the first IDLE cycle after the result is
//     written; mul_out is valid from that cycle and holds until the next
//     completed product. start may be asserted in the done cycle and is
//     accepted at the following edge (one product per NCYC+2 cycles).
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    operation request, sampled only in IDLE
//   mul_in1    in   163  operand A
//   mul_in2    in   163  operand B
//   busy       out  1    operation in progress (RUN or DONE)
//   done       out  1    one-cycle result-valid pulse
//   mul_out    out  163  A*B mod f, registered and fully reduced
//   dbg_state  out  2    current FSM state (IDLE=0, RUN=1, DONE=2)
//
// DIGIT must be one of 1, 2, 4, 8.
// -----------------------------------------------------------------------------
module gf2m_digit_mul_163b #(
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [162:0] mul_in1,
    input  logic [162:0] mul_in2,
    output logic         busy,
    output logic         done,
    output logic [162:0] mul_out,
    output logic [1:0]   dbg_state
);

    localparam int M    = 163;
    localparam int NCYC = (M + DIGIT - 1) / DIGIT;
    localparam int PW   = NCYC * DIGIT;
    localparam int CW   = $clog2(NCYC + 1);

    // Low part of f: x^163 == x^7 + x^6 + x^3 + 1 (mod f).
    localparam logic [M-1:0] F_LOW = 163'hC9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [M-1:0]      r_a;
    logic [PW-1:0]     r_b;
    logic [M-1:0]      r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_done;
    logic [M-1:0]      r_mul_out;

    logic [DIGIT-1:0]  w_digit;
    logic [M+DIGIT-1:0] w_acc_sh;
    logic [M+DIGIT-1:0] w_pp;
    logic [M-1:0]      w_acc_red;
    logic [M-1:0]      w_pp_red;
    logic [M-1:0]      w_acc_next;
    logic [PW-1:0]     w_b_pad;

    // Fold the DIGIT bits above x^162 back into the field. Bit 163+j maps to
    // x^j * (x^7 + x^6 + x^3 + 1); with DIGIT <= 8 the highest term is x^14,
    // so one fold always yields a fully reduced value.
    function automatic logic [M-1:0] fold_top(input logic [M+DIGIT-1:0] v);
        logic [M-1:0] r;
        r = v[M-1:0];
        for (int j = 0; j < DIGIT; j++) begin
            if (v[M+j]) begin
                r = r ^ (F_LOW << j);
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: one Horner step per RUN cycle
    // ------------------------------------------------------------------
    assign w_digit  = r_b[PW-1 -: DIGIT];
    assign w_b_pad  = PW'(mul_in2);

    // acc * x^DIGIT before reduction.
    assign w_acc_sh = {r_acc, {DIGIT{1'b0}}};

    // A * b_digit as an XOR of shifted copies of A (up to M+DIGIT-1 bits).
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (w_digit[j]) begin
                w_pp = w_pp ^ ({{DIGIT{1'b0}}, r_a} << j);
            end
        end
    end

    assign w_acc_red  = fold_top(w_acc_sh);
    assign w_pp_red   = fold_top(w_pp);
    assign w_acc_next = w_acc_red ^ w_pp_red;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_mul_out <= '0;
        end else begin
            // done is high exactly in the cycle after the DONE state.
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= mul_in1;
                        r_b   <= w_b_pad;
                        r_acc <= '0;
                        r_cnt <= CW'(NCYC - 1);
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    // Next digit moves into the top slice.
                    r_b   <= r_b << DIGIT;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    r_mul_out <= r_acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign done      = r_done;
    assign mul_out   = r_mul_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gf2m_digit_mul_163b.sv
// -----------------------------------------------------------------------------
// tb_gf2m_digit_mul_163b
//
// Drives three copies of the multiplier (DIGIT = 1, 4, 8) from the same
// stimulus. Products are compared against a schoolbook polynomial multiply
// followed by long-division reduction by f. Latency, busy length and done
// pulse width are checked per instance, plus hand-written sequences for
// start-while-busy, start-in-done-cycle and asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_gf2m_digit_mul_163b;

    localparam int M = 163;
    localparam int NDUT = 3;
    localparam int DIG [NDUT] = '{1, 4, 8};
    localparam int NC  [NDUT] = '{163, 41, 21};

    typedef struct {
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] exp;
    } vec_t;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;
    logic start;
    logic [M-1:0] mul_in1;
    logic [M-1:0] mul_in2;

    logic [NDUT-1:0] busy_v;
    logic [NDUT-1:0] done_v;
    logic [M-1:0]    out_v [NDUT];
    logic [1:0]      dbg_v [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gf2m_digit_mul_163b #(.DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mul_in1(mul_in1), .mul_in2(mul_in2),
        .busy(busy_v[0]), .done(done_v[0]), .mul_out(out_v[0]),
        .dbg_state(dbg_v[0])
    );

    gf2m_digit_mul_163b #(.DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mul_in1(mul_in1), .mul_in2(mul_in2),
        .busy(busy_v[1]), .done(done_v[1]), .mul_out(out_v[1]),
        .dbg_state(dbg_v[1])
    );

    gf2m_digit_mul_163b #(.DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mul_in1(mul_in1), .mul_in2(mul_in2),
        .busy(busy_v[2]), .done(done_v[2]), .mul_out(out_v[2]),
        .dbg_state(dbg_v[2])
    );

    // ------------------------------------------------------------------
    // Reference model and helpers
    // ------------------------------------------------------------------
    function automatic logic [M-1:0] gf_mul_ref(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] p;
        logic [2*M-2:0] f;
        p = '0;
        f = '0;
        f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ ({{(M-1){1'b0}}, a} << i);
        end
        for (int i = 2*M-2; i >= M; i--) begin
            if (p[i]) p = p ^ (f << (i - M));
        end
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] rand163();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[M-1:0];
    endfunction

    task automatic chk_vec(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver + monitor: one product on all three instances. Optionally
    // raises start for one cycle at cycle inject_at of the run with other
    // operands, which must be ignored.
    // ------------------------------------------------------------------
    task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b,
                          input int inject_at, input logic [M-1:0] a2,
                          input logic [M-1:0] b2, input string tag);
        logic [M-1:0] exp;
        int first_done [NDUT];
        int busy_n [NDUT];
        int done_n [NDUT];
        int cnt;
        int last;
        bit all_seen;
        exp = gf_mul_ref(a, b);
        mul_in1 = a;
        mul_in2 = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mul_in1 = rand163();
        mul_in2 = rand163();
        for (int i = 0; i < NDUT; i++) begin
            first_done[i] = -1; busy_n[i] = 0; done_n[i] = 0;
        end
        cnt = 0;
        forever begin
            for (int i = 0; i < NDUT; i++) begin
                if (first_done[i] < 0 && busy_v[i]) busy_n[i]++;
                if (done_v[i]) begin
                    done_n[i]++;
                    if (first_done[i] < 0) first_done[i] = cnt;
                end
            end
            all_seen = 1'b1;
            last = 0;
            for (int i = 0; i < NDUT; i++) begin
                if (first_done[i] < 0) all_seen = 1'b0;
                else if (first_done[i] > last) last = first_done[i];
            end
            if ((all_seen && cnt > last) || cnt >= 200) break;
            if (cnt == inject_at) begin
                start = 1'b1; mul_in1 = a2; mul_in2 = b2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            chk_vec($sformatf("%s d%0d product", tag, DIG[i]), out_v[i], exp);
            chk_int($sformatf("%s d%0d latency", tag, DIG[i]), first_done[i] + 1, NC[i] + 2);
            chk_int($sformatf("%s d%0d busy cycles", tag, DIG[i]), busy_n[i], NC[i] + 1);
            chk_int($sformatf("%s d%0d done pulses", tag, DIG[i]), done_n[i], 1);
        end
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    vec_t tbl [12];

    initial begin
        logic [M-1:0] ones;
        logic [M-1:0] x162;
        logic [M-1:0] a1, b1, a2, b2, e1, e2;
        int cnt;

        ones = {M{1'b1}};
        x162 = '0;
        x162[162] = 1'b1;

        tbl[0] = '{a: 163'h1, b: 163'h1, exp: 163'h1};
        tbl[1] = '{a: 163'h2, b: x162, exp: 163'hC9};
        tbl[2] = '{a: ones, b: '0, exp: '0};
        tbl[3] = '{a: ones, b: 163'h1, exp: ones};
        tbl[4].a = rand163();
        tbl[4].b = rand163();
        tbl[5].a = tbl[4].b;
        tbl[5].b = tbl[4].a;
        tbl[6].a = ones;
        tbl[6].b = ones;
        tbl[7].a = x162;
        tbl[7].b = x162;
        for (int i = 8; i < 12; i++) begin
            tbl[i].a = rand163();
            tbl[i].b = rand163();
        end
        for (int i = 4; i < 12; i++) begin
            tbl[i].exp = gf_mul_ref(tbl[i].a, tbl[i].b);
        end

        rst_n = 1'b0;
        start = 1'b0;
        mul_in1 = '0;
        mul_in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NDUT; i++) begin
            chk_int($sformatf("reset d%0d busy", DIG[i]), int'(busy_v[i]), 0);
            chk_int($sformatf("reset d%0d done", DIG[i]), int'(done_v[i]), 0);
            chk_vec($sformatf("reset d%0d mul_out", DIG[i]), out_v[i], '0);
        end

        // Table-driven products.
        for (int i = 0; i < 12; i++) begin
            chk_vec($sformatf("model vec%0d", i), gf_mul_ref(tbl[i].a, tbl[i].b), tbl[i].exp);
            run_op(tbl[i].a, tbl[i].b, -1, '0, '0, $sformatf("vec%0d", i));
        end

        // start again at cycle 10 of a run with other operands: ignored.
        run_op(rand163(), rand163(), 10, rand163(), rand163(), "ignore");

        // start accepted in the done cycle of the DIGIT=4 instance.
        a1 = rand163(); b1 = rand163(); a2 = rand163(); b2 = rand163();
        e1 = gf_mul_ref(a1, b1);
        e2 = gf_mul_ref(a2, b2);
        mul_in1 = a1; mul_in2 = b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (!done_v[1] && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        chk_int("b2b d4 first latency", cnt + 1, 43);
        mul_in1 = a2; mul_in2 = b2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mul_in1 = rand163(); mul_in2 = rand163();
        chk_int("b2b d4 accepted", int'(busy_v[1]), 1);
        cnt = 0;
        while (!done_v[1] && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        chk_int("b2b d4 second latency", cnt + 1, 43);
        chk_vec("b2b d4 second product", out_v[1], e2);
        cnt = 0;
        while (!done_v[0] && cnt < 200) begin
            @(posedge clk); #1; cnt++;
        end
        chk_int("b2b d1 done seen", int'(done_v[0]), 1);
        chk_vec("b2b d1 keeps first product", out_v[0], e1);
        chk_vec("b2b d8 second product", out_v[2], e2);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset at cycle 20 of a run.
        mul_in1 = rand163(); mul_in2 = rand163(); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk_int($sformatf("async rst d%0d busy", DIG[i]), int'(busy_v[i]), 0);
            chk_int($sformatf("async rst d%0d done", DIG[i]), int'(done_v[i]), 0);
            chk_vec($sformatf("async rst d%0d mul_out", DIG[i]), out_v[i], '0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NDUT; i++) begin
            chk_int($sformatf("post rst d%0d idle", DIG[i]), int'(busy_v[i]), 0);
        end
        run_op(rand163(), rand163(), -1, '0, '0, "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound in case a wait above misbehaves.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gf2m_digit_mul_163b.md
Name: gf2m_digit_mul_163b

Overview:
- Digit-serial GF(2^163) multiplier over the NIST B-163 field polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1.
- Sits directly upstream of cs_adder_163b: its registered product drives adder_in1 or adder_in2 in the point-arithmetic datapath.
- Uses a start/busy/done handshake and takes a fixed, DIGIT-dependent number of cycles per product.

Parameters:
- DIGIT, 4: bits of mul_in2 consumed per cycle; legal values 1, 2, 4, 8.
- NCYC, ceil(163/DIGIT): derived localparam, number of compute cycles (41 at default); not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- mul_in1  in  163  operand A, polynomial basis, bit i = coeff of x^i
- mul_in2  in  163  operand B, same encoding
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; mul_out valid
- mul_out  out  163  A*B mod f, registered

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE; busy=0, done=0, mul_out=0; internal A/B/accumulator/digit counter cleared. Recovery is synchronous to the first clk edge with rst_n high.
- States:
  - IDLE: busy=0. If start=1 at an edge:
    - latch A=mul_in1;
    - latch B zero-padded on the MSB side to NCYC*DIGIT bits;
    - clear accumulator; load counter=NCYC-1;
    - go to RUN.
  - RUN: busy=1. Each edge:
    - acc <= (acc * x^DIGIT mod f) XOR (A * b_digit mod f), where b_digit is the current most-significant unprocessed DIGIT-bit slice of padded B (MSB-first Horner).
    - counter decrements.
    - At counter=0, perform the final step and go to DONE.
  - DONE: on the next edge, mul_out <= acc, done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: start sampled at edge k, done high during the cycle following edge k+NCYC+1; 43 cycles start-to-done at DIGIT=4, 165 at DIGIT=1.
- mul_out holds its value until the next completed operation; it is unaffected by new start or by operand changes. It is not cleared by start.
- Start rules:
  - start while busy=1 or in DONE is ignored; no queuing, no effect on the current result.
  - start asserted in the same cycle done is high is accepted, because the state has returned to IDLE at that edge's evaluation. Back-to-back throughput is therefore one product per NCYC+2 cycles.
- Operands may change freely after the start edge; only latched copies are used.
- Reduction is fully combinational within each step:
  - x^DIGIT shift-and-reduce folds bits 163..162+DIGIT back via x^163 ≡ x^7+x^6+x^3+1.
  - A*b_digit: partial sum of up to DIGIT shifted copies of A, at most 170 bits at DIGIT=8, reduced to 163 bits in the same cycle.
- No carries anywhere: all additions are bitwise XOR. mul_out bits above 162 do not exist, and the result is always fully reduced (degree < 163).
- Reset mid-RUN: operation aborted, done never pulses, mul_out=0.

Test Plan:
- Reset, then A=163'h1, B=163'h1, start one cycle -> busy high 42 cycles, done pulses at cycle 43, mul_out=163'h1.
- A=163'h2 (x), B=163'h4_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000 (x^162) -> mul_out=163'hC9 (x^7+x^6+x^3+1).
- A=163'h7_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=0 -> mul_out=0.
- Same A, B=163'h1 -> mul_out=A.
- Swap A/B for a random pair -> results identical.
- Cross-check random pairs against a bench-side bit-serial reference model. Feed mul_out into cs_adder_163b with an equal second input -> adder_out=0.
- Assert start again at cycle 10 of a run with different operands -> ignored, original product delivered at cycle 43, busy never drops early.
- Start accepted in the done cycle -> second done exactly 43 cycles later.
- Pull rst_n low at cycle 20 of a run -> busy=0, done=0, mul_out=0 immediately (asynchronous). A new start after release completes normally.
- Regress at DIGIT=1 and DIGIT=8 -> done latency 165 and 23 cycles respectively, with identical products.
